// File: rtl/multicycle_control_if.sv
// Handshake/control bundle between the multicycle controller and its datapath/testbench.
interface multicycle_control_if;
    logic        start_i;
    logic [5:0]  op_i;
    logic        mem_ready_i;

    logic        PCWrite_o;
    logic        PCWriteCond_o;
    logic        IorD_o;
    logic        MemRead_o;
    logic        MemWrite_o;
    logic        IRWrite_o;
    logic        MemtoReg_o;
    logic        RegWrite_o;
    logic        RegDst_o;
    logic        ALUSrcA_o;
    logic [1:0]  ALUSrcB_o;
    logic [1:0]  PCSource_o;
    logic [1:0]  ALUOp_o;
    logic        err_o;
    logic [3:0]  state_o;
    logic [31:0] instret_o;

    // Stimulus side: drives start/opcode/memory-ready, observes controls.
    modport master (
        output start_i, op_i, mem_ready_i,
        input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
               MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o, ALUSrcB_o, PCSource_o,
               ALUOp_o, err_o, state_o, instret_o
    );

    // Controller side.
    modport slave (
        input  start_i, op_i, mem_ready_i,
        output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
               MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o, ALUSrcB_o, PCSource_o,
               ALUOp_o, err_o, state_o, instret_o
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a classic multicycle MIPS-like datapath,
// with memory-wait stalls and a retired-instruction counter.
module multicycle_control (
    input  logic                 clk_i,
    input  logic                 rst_i,
    multicycle_control_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADDR = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_IEXEC   = 4'd9,
        S_IWB     = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;

    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_write, reg_dst, alu_src_a, err;
    logic [1:0]  alu_src_b, pc_source, alu_op;

    // State register; reset returns to IDLE asynchronously so controls drop at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: memory states stall on mem_ready_i, IDLE is left only via start_i.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (bus.start_i) state_d = S_FETCH;
            S_FETCH:   if (bus.mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                unique case (bus.op_i)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_ADDI:       state_d = S_IEXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MEMADDR: state_d = (bus.op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (bus.mem_ready_i) state_d = S_MEMWB;
            S_MEMWR:   if (bus.mem_ready_i) state_d = S_FETCH;
            S_MEMWB:   state_d = S_FETCH;
            S_EXEC:    state_d = S_RWB;
            S_RWB:     state_d = S_FETCH;
            S_IEXEC:   state_d = S_IWB;
            S_IWB:     state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_IDLE;
        endcase
    end

    // Control decode from the registered state; only the fetch-completion
    // strobes look at mem_ready_i, and err looks at the latched opcode in DECODE.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = 2'b00;
        err           = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready_i;
                pc_write  = bus.mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                err = !(bus.op_i inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J});
            end
            S_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b11;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
            end
            S_IWB:     reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: ;
        endcase
    end

    // An instruction retires on the clock edge that leaves its final state.
    always_comb begin
        retire = 1'b0;
        unique case (state_q)
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEMWR: retire = bus.mem_ready_i;
            default: retire = 1'b0;
        endcase
        instret_d = retire ? instret_q + 32'd1 : instret_q;
    end

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) instret_q <= 32'd0;
        else       instret_q <= instret_d;
    end

    assign bus.PCWrite_o     = pc_write;
    assign bus.PCWriteCond_o = pc_write_cond;
    assign bus.IorD_o        = iord;
    assign bus.MemRead_o     = mem_read;
    assign bus.MemWrite_o    = mem_write;
    assign bus.IRWrite_o     = ir_write;
    assign bus.MemtoReg_o    = mem_to_reg;
    assign bus.RegWrite_o    = reg_write;
    assign bus.RegDst_o      = reg_dst;
    assign bus.ALUSrcA_o     = alu_src_a;
    assign bus.ALUSrcB_o     = alu_src_b;
    assign bus.PCSource_o    = pc_source;
    assign bus.ALUOp_o       = alu_op;
    assign bus.err_o         = err;
    assign bus.state_o       = state_q;
    assign bus.instret_o     = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control; inputs change and outputs
// are sampled on the falling clock edge.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.op_i        = 6'b000000;
        bus.mem_ready_i = 1'b0;

        // Reset state
        #1;
        chk("rst_state",   bus.state_o,   0);
        chk("rst_memread", bus.MemRead_o, 0);
        chk("rst_instret", bus.instret_o, 0);
        chk("rst_err",     bus.err_o,     0);
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        chk("idle_hold", bus.state_o, 0);
        chk("idle_ctl",  {bus.MemRead_o, bus.PCWrite_o, bus.ALUSrcB_o}, 0);

        // lw, no memory wait: 1,2,3,4,5,1
        bus.start_i = 1'b1; bus.op_i = 6'b100011; bus.mem_ready_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        chk("lw_fetch",    bus.state_o, 1);
        chk("lw_fetch_ctl", {bus.MemRead_o, bus.IRWrite_o, bus.PCWrite_o, bus.IorD_o, bus.ALUSrcB_o}, 6'b111001);
        step();
        chk("lw_decode",   bus.state_o, 2);
        chk("lw_dec_srcb", bus.ALUSrcB_o, 2'b11);
        step();
        chk("lw_memaddr",  bus.state_o, 3);
        chk("lw_ma_ctl",   {bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALUOp_o}, 5'b11000);
        step();
        chk("lw_memrd",    bus.state_o, 4);
        chk("lw_rd_ctl",   {bus.MemRead_o, bus.IorD_o, bus.MemWrite_o}, 3'b110);
        step();
        chk("lw_memwb",    bus.state_o, 5);
        chk("lw_wb_ctl",   {bus.RegWrite_o, bus.MemtoReg_o, bus.RegDst_o}, 3'b110);
        chk("lw_pre_ret",  bus.instret_o, 0);
        step();
        chk("lw_back",     bus.state_o, 1);
        chk("lw_instret",  bus.instret_o, 1);

        // sw with 3 wait cycles in MEMWR: retires after 7 cycles
        bus.op_i = 6'b101011;
        step();
        chk("sw_decode",   bus.state_o, 2);
        step();
        chk("sw_memaddr",  bus.state_o, 3);
        bus.mem_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) bus.mem_ready_i = 1'b1;
            chk($sformatf("sw_wait%0d_state", i), bus.state_o, 6);
            chk($sformatf("sw_wait%0d_ctl", i),
                {bus.MemWrite_o, bus.IorD_o, bus.MemRead_o, bus.RegWrite_o}, 4'b1100);
            chk($sformatf("sw_wait%0d_ret", i), bus.instret_o, 1);
        end
        step();
        chk("sw_back",     bus.state_o, 1);
        chk("sw_instret",  bus.instret_o, 2);

        // beq then j: +2 retired in 6 cycles
        bus.op_i = 6'b000100;
        step();
        step();
        chk("beq_state",   bus.state_o, 11);
        chk("beq_ctl",     {bus.PCWriteCond_o, bus.PCSource_o, bus.ALUOp_o, bus.ALUSrcA_o, bus.PCWrite_o}, 7'b1010110);
        step();
        chk("beq_back",    bus.state_o, 1);
        bus.op_i = 6'b000010;
        step();
        step();
        chk("j_state",     bus.state_o, 12);
        chk("j_ctl",       {bus.PCWrite_o, bus.PCSource_o, bus.PCWriteCond_o}, 4'b1100);
        step();
        chk("j_back",      bus.state_o, 1);
        chk("bj_instret",  bus.instret_o, 4);

        // Illegal opcode: err for one DECODE cycle, no retire
        bus.op_i = 6'b111111;
        step();
        chk("ill_decode",  bus.state_o, 2);
        chk("ill_err",     bus.err_o, 1);
        step();
        chk("ill_back",    bus.state_o, 1);
        chk("ill_err_off", bus.err_o, 0);
        chk("ill_instret", bus.instret_o, 4);

        // addi: IEXEC then IWB
        bus.op_i = 6'b001000;
        step();
        step();
        chk("addi_exec",   {bus.state_o, bus.ALUOp_o, bus.ALUSrcB_o, bus.ALUSrcA_o}, {4'd9, 2'b10, 2'b10, 1'b1});
        step();
        chk("addi_wb",     {bus.state_o, bus.RegWrite_o, bus.RegDst_o, bus.MemtoReg_o}, {4'd10, 3'b100});
        step();
        chk("addi_instret", bus.instret_o, 5);

        // R-type with the counter preloaded to all-ones: must wrap to 0
        bus.op_i = 6'b000000;
        dut.instret_q <= 32'hFFFF_FFFF;
        step();
        chk("r_decode",    bus.state_o, 2);
        chk("r_preload",   bus.instret_o, 32'hFFFF_FFFF);
        step();
        chk("r_exec",      {bus.state_o, bus.ALUOp_o, bus.ALUSrcA_o, bus.ALUSrcB_o}, {4'd7, 2'b11, 1'b1, 2'b00});
        step();
        chk("r_rwb",       {bus.state_o, bus.RegWrite_o, bus.RegDst_o, bus.MemtoReg_o}, {4'd8, 3'b110});
        step();
        chk("r_wrap",      bus.instret_o, 0);

        // Fetch stall: IRWrite/PCWrite only with mem_ready_i, then lw stalled in MEMRD
        bus.op_i = 6'b100011; bus.mem_ready_i = 1'b0;
        step();
        chk("stall_fetch", {bus.state_o, bus.MemRead_o, bus.IRWrite_o, bus.PCWrite_o}, {4'd1, 3'b100});
        bus.mem_ready_i = 1'b1;
        #1;
        chk("fetch_done",  {bus.IRWrite_o, bus.PCWrite_o}, 2'b11);
        step();
        step();
        bus.mem_ready_i = 1'b0;
        step();
        chk("rd_wait",     {bus.state_o, bus.MemRead_o, bus.MemWrite_o}, {4'd4, 2'b10});
        step();
        chk("rd_wait2",    {bus.state_o, bus.MemRead_o}, {4'd4, 1'b1});

        // Reset mid-access drops MemRead before the next rising edge
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_memread", bus.MemRead_o, 0);
        chk("mid_rst_state",   bus.state_o, 0);
        chk("mid_rst_instret", bus.instret_o, 0);
        #1 rst = 1'b0;
        bus.mem_ready_i = 1'b1;
        step();
        step();
        chk("post_rst_idle", bus.state_o, 0);
        bus.start_i = 1'b1;
        step();
        chk("restart",     bus.state_o, 1);
        bus.start_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock, rising-edge.
REQ-002 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port start_i  in  1  leave IDLE and begin fetching.
REQ-004 SHALL have port op_i  in  6  opcode field of the instruction register; stable after IRWrite.
REQ-005 SHALL have port mem_ready_i  in  1  memory access completes this cycle.
REQ-006 SHALL have outputs PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o  out  1 each  standard multicycle datapath controls.
REQ-007 SHALL have outputs ALUSrcB_o, PCSource_o, ALUOp_o  out  2 each.
- ALUSrcB: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- PCSource: 00 ALU result, 01 ALUOut, 10 jump target.
- ALUOp: 00 add, 01 sub, 10 immediate add, 11 funct-decoded.
REQ-008 SHALL have port err_o  out  1  one-cycle pulse on an illegal opcode.
REQ-009 SHALL have port state_o  out  4  current state encoding, for debug.
REQ-010 SHALL have port instret_o  out  32  count of retired instructions.

Function
REQ-011 SHALL be a Moore FSM; all controls SHALL be decoded from the registered state only, except the memory-wait qualifications in REQ-013 to REQ-018.
REQ-012 SHALL use states IDLE=0, FETCH=1, DECODE=2, MEMADDR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, IEXEC=9, IWB=10, BRANCH=11, JUMP=12.
REQ-013 IDLE: all controls 0; go to FETCH when start_i=1, else stay in IDLE.
REQ-014 FETCH: drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
- IRWrite and PCWrite SHALL be 1 only in the cycle mem_ready_i=1.
- On that cycle go to DECODE; otherwise stay in FETCH.
REQ-015 DECODE: drive ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
- 000000 -> EXEC
- 001000 -> IEXEC
- 100011 or 101011 -> MEMADDR
- 000100 -> BRANCH
- 000010 -> JUMP
- any other -> FETCH, with err_o=1 for that cycle.
REQ-016 MEMADDR: drive ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if the opcode is lw, otherwise MEMWR.
REQ-017 MEMRD: drive MemRead=1, IorD=1. Hold until mem_ready_i=1, then go to MEMWB.
REQ-018 MEMWR: drive MemWrite=1, IorD=1. Hold until mem_ready_i=1, then go to FETCH; the instruction retires.
REQ-019 MEMWB: drive RegWrite=1, MemtoReg=1, RegDst=0; go to FETCH; retires.
REQ-020 EXEC: drive ALUSrcA=1, ALUSrcB=00, ALUOp=11; go to RWB.
REQ-021 RWB: drive RegWrite=1, RegDst=1, MemtoReg=0; go to FETCH; retires.
REQ-022 IEXEC: drive ALUSrcA=1, ALUSrcB=10, ALUOp=10; go to IWB.
REQ-023 IWB: drive RegWrite=1, RegDst=0, MemtoReg=0; go to FETCH; retires.
REQ-024 BRANCH: drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; go to FETCH; retires.
REQ-025 JUMP: drive PCWrite=1, PCSource=10; go to FETCH; retires.
REQ-026 Latency from FETCH entry to retire, with zero memory wait, SHALL be: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3. Each mem_ready_i=0 cycle SHALL add one cycle.
REQ-027 MemRead and MemWrite SHALL never both be 1, and SHALL be held stable during a memory wait.
REQ-028 instret_o SHALL increment by 1 on the final-state clock edge of each retired instruction and wrap from 0xFFFFFFFF to 0. Illegal opcodes SHALL NOT increment it.
REQ-029 start_i SHALL be ignored outside IDLE; the FSM never returns to IDLE except by reset.
REQ-030 All outputs not driven in a state SHALL be 0.

Reset
REQ-031 rst_i=1 SHALL immediately force state=IDLE, all controls 0, err_o=0, and instret_o=0, independent of clk_i.
REQ-032 A reset asserted mid-access SHALL drop MemRead/MemWrite in the same cycle; no partial retire.
REQ-033 After rst_i deasserts, the FSM SHALL remain in IDLE until start_i=1.

Verification
REQ-034 Reset, start_i=1, mem_ready_i=1, op=100011 -> states 1,2,3,4,5,1; RegWrite=1 and MemtoReg=1 in MEMWB; instret_o=1.
REQ-035 op=101011, mem_ready_i held 0 for 3 cycles in MEMWR -> MemWrite=1 and IorD=1 stable for 4 cycles; retires in 7 cycles; RegWrite never 1.
REQ-036 op=000100, then op=000010 -> BRANCH shows PCWriteCond=1, PCSource=01, ALUOp=01; JUMP shows PCWrite=1, PCSource=10; instret_o advances by 2 in 6 cycles.
REQ-037 op=111111 -> err_o=1 for one cycle in DECODE, next state FETCH, instret_o unchanged.
REQ-038 rst_i pulsed while in MEMRD with MemRead=1 -> MemRead=0 before the next clk_i edge, state_o=0, instret_o=0.
REQ-039 Preload instret_o to 0xFFFFFFFF, then retire an R-type instruction -> instret_o=0; ALUOp=11 in EXEC; RegDst=1 in RWB.
